// File: rtl/simon_sequencer.sv
// Simon memory game sequencer: grows a random colour sequence by one step per round,
// plays it back on the LEDs, then checks the player's button presses against it.
module simon_sequencer #(
  parameter int MAX_LEN    = 32,
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 12500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] rand_in,
  input  logic [3:0] btn,
  output logic [3:0] led,
  output logic [6:0] score,
  output logic       busy,
  output logic       game_over,
  output logic       win
);

  localparam int LENW = $clog2(MAX_LEN + 1);
  localparam int IDXW = $clog2(MAX_LEN);
  localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam logic [TW-1:0]   ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]   OFF_LAST = TW'(OFF_CYCLES - 1);
  localparam logic [LENW-1:0] LEN_MAX  = LENW'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_ADD, S_SHOW_ON, S_SHOW_OFF, S_INPUT, S_FAIL, S_WIN
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [LENW-1:0] r_len, w_len_nxt;
  logic [IDXW-1:0] r_idx, w_idx_nxt;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic [6:0]      r_score, w_score_nxt;
  logic [3:0]      r_btn_q;
  logic [1:0]      r_mem [MAX_LEN];
  logic            w_mem_we;
  logic            w_press;
  logic            w_last;
  logic [3:0]      w_expect;

  assign w_press  = (btn != '0) && (r_btn_q == '0);
  assign w_expect = 4'b0001 << r_mem[r_idx];
  assign w_last   = ((LENW'(r_idx) + LENW'(1)) == r_len);

  // Timer is zeroed by default, so every state transition reloads it.
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    w_timer_nxt = '0;
    w_score_nxt = r_score;
    w_mem_we    = 1'b0;
    case (r_state)
      S_IDLE, S_FAIL, S_WIN: begin
        if (start) begin
          w_state_nxt = S_ADD;
          w_len_nxt   = '0;
          w_idx_nxt   = '0;
          w_score_nxt = '0;
        end
      end
      S_ADD: begin
        w_mem_we    = 1'b1;
        w_len_nxt   = r_len + LENW'(1);
        w_idx_nxt   = '0;
        w_state_nxt = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (r_timer == ON_LAST) w_state_nxt = S_SHOW_OFF;
        else                    w_timer_nxt = r_timer + TW'(1);
      end
      S_SHOW_OFF: begin
        if (r_timer == OFF_LAST) begin
          if (w_last) begin
            w_state_nxt = S_INPUT;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = S_SHOW_ON;
            w_idx_nxt   = r_idx + IDXW'(1);
          end
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_INPUT: begin
        if (w_press) begin
          if (btn != w_expect) begin
            w_state_nxt = S_FAIL;
          end else if (!w_last) begin
            w_idx_nxt = r_idx + IDXW'(1);
          end else begin
            w_score_nxt = r_score + 7'd1;
            w_state_nxt = (r_len == LEN_MAX) ? S_WIN : S_ADD;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_timer <= '0;
      r_score <= '0;
      r_btn_q <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_idx   <= w_idx_nxt;
      r_timer <= w_timer_nxt;
      r_score <= w_score_nxt;
      r_btn_q <= btn;
    end
  end

  // Sequence storage carries no reset; a slot is only read after ADD has written it.
  always_ff @(posedge clk) begin
    if (reset_n && w_mem_we) r_mem[r_len[IDXW-1:0]] <= rand_in;
  end

  // INPUT echo uses the registered button history, which equals btn as last sampled.
  always_comb begin
    led = '0;
    case (r_state)
      S_SHOW_ON: led = w_expect;
      S_INPUT:   led = r_btn_q;
      default:   led = '0;
    endcase
  end

  assign score     = r_score;
  assign busy      = (r_state == S_ADD) || (r_state == S_SHOW_ON) || (r_state == S_SHOW_OFF);
  assign game_over = (r_state == S_FAIL);
  assign win       = (r_state == S_WIN);

endmodule

// File: tb/tb_simon_sequencer.sv
// Bench for simon_sequencer with MAX_LEN=4, ON_CYCLES=4, OFF_CYCLES=2: per-cycle expected
// outputs are queued as inputs are driven and compared after the clock edge.
module tb_simon_sequencer;

  localparam int MAXL = 4;
  localparam int ONC  = 4;
  localparam int OFFC = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [1:0] rand_in;
  logic [3:0] btn;
  logic [3:0] led;
  logic [6:0] score;
  logic       busy;
  logic       game_over;
  logic       win;

  simon_sequencer #(
    .MAX_LEN(MAXL),
    .ON_CYCLES(ONC),
    .OFF_CYCLES(OFFC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .rand_in(rand_in),
    .btn(btn),
    .led(led),
    .score(score),
    .busy(busy),
    .game_over(game_over),
    .win(win)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] led;
    logic [6:0] score;
    logic       busy;
    logic       go;
    logic       win;
  } exp_t;

  typedef struct {
    logic       rn;
    logic       st;
    logic [1:0] rd;
    logic [3:0] b;
    exp_t       e;
    string      nm;
  } vec_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    exp_score = 0;
  logic [1:0] exp_seq [MAXL];

  function automatic exp_t mk(input logic [3:0] l, input int s, input logic b,
                              input logic g, input logic w);
    exp_t e;
    e.led = l; e.score = 7'(s); e.busy = b; e.go = g; e.win = w;
    return e;
  endfunction

  task automatic compare_one();
    exp_t  e;
    exp_t  got;
    string nm;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    got.led = led; got.score = score; got.busy = busy; got.go = game_over; got.win = win;
    n_checks++;
    if (got !== e)
      $display("FAIL %s: got led=%b score=%0d busy=%b game_over=%b win=%b, expected led=%b score=%0d busy=%b game_over=%b win=%b",
               nm, got.led, got.score, got.busy, got.go, got.win,
               e.led, e.score, e.busy, e.go, e.win);
    else
      n_pass++;
  endtask

  task automatic cyc(input logic rn, input logic st, input logic [1:0] rd, input logic [3:0] b,
                     input exp_t e, input string nm);
    reset_n = rn; start = st; rand_in = rd; btn = b;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    @(negedge clk);
    compare_one();
  endtask

  // Playback of n steps; the first cycle is the ADD edge that stores newc.
  task automatic show(input int n, input logic [1:0] newc, input logic [3:0] hb, input int hn);
    int k;
    logic [1:0] rd;
    exp_seq[n-1] = newc;
    k = 0;
    for (int i = 0; i < n; i++) begin
      for (int t = 0; t < ONC + OFFC; t++) begin
        rd = (k == 0) ? newc : 2'($urandom_range(3));
        cyc(1'b1, 1'b0, rd, (k < hn) ? hb : 4'b0000,
            mk((t < ONC) ? (4'b0001 << exp_seq[i]) : 4'b0000, exp_score, 1'b1, 1'b0, 1'b0),
            (t < ONC) ? "show_on" : "show_off");
        k++;
      end
    end
    cyc(1'b1, 1'b0, 2'($urandom_range(3)), 4'b0000,
        mk(4'b0000, exp_score, 1'b0, 1'b0, 1'b0), "input_entry");
  endtask

  // Correct replay of n steps, releasing between presses.
  task automatic answer(input int n);
    logic [3:0] b;
    for (int i = 0; i < n; i++) begin
      b = 4'b0001 << exp_seq[i];
      if (i < n - 1) begin
        cyc(1'b1, 1'b0, 2'($urandom_range(3)), b, mk(b, exp_score, 1'b0, 1'b0, 1'b0), "press_ok");
        cyc(1'b1, 1'b0, 2'($urandom_range(3)), 4'b0000,
            mk(4'b0000, exp_score, 1'b0, 1'b0, 1'b0), "release");
      end else begin
        exp_score++;
        if (n == MAXL)
          cyc(1'b1, 1'b0, 2'($urandom_range(3)), b, mk(4'b0000, exp_score, 1'b0, 1'b0, 1'b1), "win");
        else
          cyc(1'b1, 1'b0, 2'($urandom_range(3)), b, mk(4'b0000, exp_score, 1'b1, 1'b0, 1'b0), "round_done");
      end
    end
  endtask

  vec_t vecs [10];

  initial begin
    reset_n = 1'b0; start = 1'b0; rand_in = 2'd0; btn = 4'b0000;

    vecs[0] = '{1'b0, 1'b0, 2'd0, 4'b0000, mk(4'b0000, 0, 1'b0, 1'b0, 1'b0), "reset"};
    vecs[1] = '{1'b0, 1'b1, 2'd1, 4'b0100, mk(4'b0000, 0, 1'b0, 1'b0, 1'b0), "reset_priority"};
    vecs[2] = '{1'b1, 1'b1, 2'd2, 4'b0000, mk(4'b0000, 0, 1'b1, 1'b0, 1'b0), "start_add"};
    for (int i = 0; i < 4; i++)
      vecs[3+i] = '{1'b1, 1'b0, 2'd2, 4'b0000, mk(4'b0100, 0, 1'b1, 1'b0, 1'b0), "r1_on"};
    for (int i = 0; i < 2; i++)
      vecs[7+i] = '{1'b1, 1'b0, 2'd1, 4'b0000, mk(4'b0000, 0, 1'b1, 1'b0, 1'b0), "r1_off"};
    vecs[9] = '{1'b1, 1'b0, 2'd3, 4'b0000, mk(4'b0000, 0, 1'b0, 1'b0, 1'b0), "r1_input"};

    for (int i = 0; i < 10; i++)
      cyc(vecs[i].rn, vecs[i].st, vecs[i].rd, vecs[i].b, vecs[i].e, vecs[i].nm);
    exp_seq[0] = 2'd2;

    // Held press counts once; next round appends colour 0.
    answer(1);
    show(2, 2'd0, 4'b0100, 2);

    // Correct first step held, then wrong colour.
    cyc(1'b1, 1'b0, 2'd1, 4'b0100, mk(4'b0100, 1, 1'b0, 1'b0, 1'b0), "r2_press0");
    cyc(1'b1, 1'b0, 2'd1, 4'b0100, mk(4'b0100, 1, 1'b0, 1'b0, 1'b0), "r2_hold_no_retrigger");
    cyc(1'b1, 1'b0, 2'd1, 4'b0000, mk(4'b0000, 1, 1'b0, 1'b0, 1'b0), "r2_release");
    cyc(1'b1, 1'b0, 2'd1, 4'b0010, mk(4'b0000, 1, 1'b0, 1'b1, 1'b0), "wrong_colour_fail");
    cyc(1'b1, 1'b0, 2'd1, 4'b0000, mk(4'b0000, 1, 1'b0, 1'b1, 1'b0), "fail_hold_score");
    exp_score = 0;
    cyc(1'b1, 1'b1, 2'd2, 4'b0000, mk(4'b0000, 0, 1'b1, 1'b0, 1'b0), "restart_from_fail");

    // Two bits pressed where one was expected.
    show(1, 2'd2, 4'b0000, 0);
    cyc(1'b1, 1'b0, 2'd0, 4'b0101, mk(4'b0000, 0, 1'b0, 1'b1, 1'b0), "multibit_fail");
    cyc(1'b1, 1'b1, 2'd0, 4'b0000, mk(4'b0000, 0, 1'b1, 1'b0, 1'b0), "restart_game3");

    // Full game to WIN.
    show(1, 2'd3, 4'b0000, 0); answer(1);
    show(2, 2'd1, 4'b0000, 0); answer(2);
    show(3, 2'd0, 4'b0000, 0); answer(3);
    show(4, 2'd2, 4'b0000, 0); answer(4);
    cyc(1'b1, 1'b0, 2'd0, 4'b0000, mk(4'b0000, 4, 1'b0, 1'b0, 1'b1), "win_release");
    cyc(1'b1, 1'b0, 2'd0, 4'b0001, mk(4'b0000, 4, 1'b0, 1'b0, 1'b1), "win_ignore_btn");
    cyc(1'b1, 1'b0, 2'd0, 4'b0000, mk(4'b0000, 4, 1'b0, 1'b0, 1'b1), "win_ignore_rel");
    cyc(1'b1, 1'b0, 2'd0, 4'b1000, mk(4'b0000, 4, 1'b0, 1'b0, 1'b1), "win_ignore_btn2");
    exp_score = 0;
    cyc(1'b1, 1'b1, 2'd1, 4'b0000, mk(4'b0000, 0, 1'b1, 1'b0, 1'b0), "restart_from_win");

    // Reset in the middle of round-2 playback.
    show(1, 2'd1, 4'b0000, 0);
    answer(1);
    cyc(1'b1, 1'b0, 2'd3, 4'b0000, mk(4'b0010, 1, 1'b1, 1'b0, 1'b0), "r2_show_on_a");
    cyc(1'b1, 1'b0, 2'd0, 4'b0000, mk(4'b0010, 1, 1'b1, 1'b0, 1'b0), "r2_show_on_b");
    cyc(1'b0, 1'b1, 2'd0, 4'b0001, mk(4'b0000, 0, 1'b0, 1'b0, 1'b0), "reset_mid_show");
    cyc(1'b1, 1'b0, 2'd0, 4'b0000, mk(4'b0000, 0, 1'b0, 1'b0, 1'b0), "idle_after_reset");
    exp_score = 0;
    cyc(1'b1, 1'b1, 2'd3, 4'b0000, mk(4'b0000, 0, 1'b1, 1'b0, 1'b0), "restart_after_reset");
    show(1, 2'd3, 4'b0000, 0);
    answer(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
